// File: rtl/alu_seq_pkg.sv
// Shared funct codes, ALU operation codes and FSM state encoding for the ALU sequencer.
// The codes follow the MIPS R-type funct field, which the ALU also uses as its operation select.
package alu_seq_pkg;

  localparam logic [5:0] FUNCT_ADD   = 6'd32;
  localparam logic [5:0] FUNCT_SUB   = 6'd34;
  localparam logic [5:0] FUNCT_AND   = 6'd36;
  localparam logic [5:0] FUNCT_OR    = 6'd37;
  localparam logic [5:0] FUNCT_SLT   = 6'd42;
  localparam logic [5:0] FUNCT_MULTU = 6'd25;

  localparam logic [5:0] ALU_OP_AND = 6'd36;
  localparam logic [5:0] ALU_OP_OR  = 6'd37;
  localparam logic [5:0] ALU_OP_ADD = 6'd32;
  localparam logic [5:0] ALU_OP_SUB = 6'd34;
  localparam logic [5:0] ALU_OP_SLT = 6'd42;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_exec_funct(input logic [5:0] f);
    return (f == FUNCT_AND) || (f == FUNCT_OR) || (f == FUNCT_ADD) ||
           (f == FUNCT_SUB) || (f == FUNCT_SLT);
  endfunction

  // SUB and SLT both run as a + ~b + 1 inside the ALU.
  function automatic logic needs_invert(input logic [5:0] f);
    return (f == FUNCT_SUB) || (f == FUNCT_SLT);
  endfunction

  function automatic logic is_multu(input logic [5:0] f);
    return f == FUNCT_MULTU;
  endfunction

  function automatic logic [5:0] alu_op_of(input logic [5:0] f);
    logic [5:0] op;
    op = ALU_OP_AND;
    case (f)
      FUNCT_OR:  op = ALU_OP_OR;
      FUNCT_ADD: op = ALU_OP_ADD;
      FUNCT_SUB: op = ALU_OP_SUB;
      FUNCT_SLT: op = ALU_OP_SLT;
      default:   op = ALU_OP_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request/response and external-ALU signals of the ALU sequencer.
// slave = the sequencer, master = the requester plus ALU environment.
interface alu_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_funct;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [5:0]       alu_operation;
  logic             alu_bit_invert;
  logic             alu_cin;
  logic [WIDTH-1:0] alu_result;
  logic             alu_cout;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [WIDTH-1:0] out_hi;
  logic             out_zero;
  logic             out_err;

  modport slave (
    input  in_valid, in_funct, in_a, in_b, alu_result, alu_cout, out_ready,
    output in_ready, alu_a, alu_b, alu_operation, alu_bit_invert, alu_cin,
           out_valid, out_result, out_hi, out_zero, out_err
  );

  modport master (
    output in_valid, in_funct, in_a, in_b, alu_result, alu_cout, out_ready,
    input  in_ready, alu_a, alu_b, alu_operation, alu_bit_invert, alu_cin,
           out_valid, out_result, out_hi, out_zero, out_err
  );
endinterface

// File: rtl/alu_seq_mul_dp.sv
// MULTU datapath: hi/lo/multiplicand registers and the per-iteration shift, using the
// external ALU as the adder (alu_a = hi, alu_b = multiplicand).
module alu_seq_mul_dp #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic             alu_cout_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] mcand_o,
  output logic [WIDTH-1:0] hi_d_o,
  output logic [WIDTH-1:0] lo_d_o
);
  logic [WIDTH-1:0] hi_q, lo_q, mcand_q;
  logic [WIDTH-1:0] hi_d, lo_d;

  // lo starts as the multiplier; its LSB picks add-then-shift or plain shift.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (load_i) begin
      hi_d = '0;
      lo_d = a_i;
    end else if (step_i) begin
      if (lo_q[0]) begin
        hi_d = {alu_cout_i, alu_result_i[WIDTH-1:1]};
        lo_d = {alu_result_i[0], lo_q[WIDTH-1:1]};
      end else begin
        hi_d = {1'b0, hi_q[WIDTH-1:1]};
        lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      if (load_i) mcand_q <= b_i;
    end
  end

  assign hi_o    = hi_q;
  assign mcand_o = mcand_q;
  assign hi_d_o  = hi_d;
  assign lo_d_o  = lo_d;
endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequences one request at a time through an external ALU; MULTU runs as WIDTH shift-add steps.
// Build option: define ALU_SEQ_CTRL_MULTU_EN to enable MULTU (funct 25); otherwise it is illegal.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst_n,
  alu_seq_ctrl_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for a request, in_ready high
  // EXEC  | one-cycle ALU op (or illegal funct, ALU unused)
  // MUL   | one shift-add iteration per cycle
  // DONE  | result held until out_ready

  state_t           state_q;
  logic [5:0]       funct_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             in_ready_q, out_valid_q, out_zero_q, out_err_q;
  logic [WIDTH-1:0] out_result_q, out_hi_q;
  logic             accept;

  logic [WIDTH-1:0] drv_a, drv_b;
  logic [5:0]       drv_op;
  logic             drv_inv, drv_cin;

  assign accept = bus.in_valid && in_ready_q;

`ifdef ALU_SEQ_CTRL_MULTU_EN
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] mul_hi, mul_mcand, mul_hi_d, mul_lo_d;

  alu_seq_mul_dp #(.WIDTH(WIDTH)) u_mul_dp (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (accept && is_multu(bus.in_funct)),
    .step_i       (state_q == ST_MUL),
    .a_i          (bus.in_a),
    .b_i          (bus.in_b),
    .alu_result_i (bus.alu_result),
    .alu_cout_i   (bus.alu_cout),
    .hi_o         (mul_hi),
    .mcand_o      (mul_mcand),
    .hi_d_o       (mul_hi_d),
    .lo_d_o       (mul_lo_d)
  );
`else
  logic unused_cout;
  assign unused_cout = bus.alu_cout;
`endif

  // Outside EXEC/MUL the ALU sees a harmless AND of zeros.
  always_comb begin
    drv_a   = '0;
    drv_b   = '0;
    drv_op  = ALU_OP_AND;
    drv_inv = 1'b0;
    drv_cin = 1'b0;
    case (state_q)
      ST_EXEC: begin
        if (is_exec_funct(funct_q)) begin
          drv_a   = a_q;
          drv_b   = b_q;
          drv_op  = alu_op_of(funct_q);
          drv_inv = needs_invert(funct_q);
          drv_cin = needs_invert(funct_q);
        end
      end
`ifdef ALU_SEQ_CTRL_MULTU_EN
      ST_MUL: begin
        drv_a  = mul_hi;
        drv_b  = mul_mcand;
        drv_op = ALU_OP_ADD;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      funct_q      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_hi_q     <= '0;
      out_zero_q   <= 1'b0;
      out_err_q    <= 1'b0;
`ifdef ALU_SEQ_CTRL_MULTU_EN
      cnt_q        <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            in_ready_q <= 1'b0;
            funct_q    <= bus.in_funct;
            a_q        <= bus.in_a;
            b_q        <= bus.in_b;
`ifdef ALU_SEQ_CTRL_MULTU_EN
            state_q    <= is_multu(bus.in_funct) ? ST_MUL : ST_EXEC;
`else
            state_q    <= ST_EXEC;
`endif
          end
        end
        ST_EXEC: begin
          state_q     <= ST_DONE;
          out_valid_q <= 1'b1;
          out_hi_q    <= '0;
          if (is_exec_funct(funct_q)) begin
            out_result_q <= bus.alu_result;
            out_zero_q   <= (bus.alu_result == '0);
            out_err_q    <= 1'b0;
          end else begin
            out_result_q <= '0;
            out_zero_q   <= 1'b1;
            out_err_q    <= 1'b1;
          end
        end
`ifdef ALU_SEQ_CTRL_MULTU_EN
        ST_MUL: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            cnt_q        <= '0;
            state_q      <= ST_DONE;
            out_valid_q  <= 1'b1;
            out_result_q <= mul_lo_d;
            out_hi_q     <= mul_hi_d;
            out_zero_q   <= (mul_lo_d == '0) && (mul_hi_d == '0);
            out_err_q    <= 1'b0;
          end
        end
`endif
        ST_DONE: begin
          if (bus.out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_result     = out_result_q;
  assign bus.out_hi         = out_hi_q;
  assign bus.out_zero       = out_zero_q;
  assign bus.out_err        = out_err_q;
  assign bus.alu_a          = drv_a;
  assign bus.alu_b          = drv_b;
  assign bus.alu_operation  = drv_op;
  assign bus.alu_bit_invert = drv_inv;
  assign bus.alu_cin        = drv_cin;
endmodule
